// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single external memory port between the I-cache and D-cache
// line miss paths. One line transfer is in flight at a time. Each transfer
// uses a req/ready handshake toward memory and a one-cycle ack toward the
// requesting cache. The core stall is asserted while any miss is outstanding.
//
// Parameters:
//   ADDR_W        byte address width
//   LINE_W        cache line width in bits
//
// Ports:
//   clk_i         clock; all state updates on the rising edge
//   rsn_i         asynchronous active-low reset
//   ic_req_i      I-cache line read request, held until ic_ack_o
//   ic_addr_i     I-cache line address
//   ic_ack_o      one-cycle pulse: I-cache fill complete, fill_data_o valid
//   dc_req_i      D-cache request, held until dc_ack_o
//   dc_we_i       1 = line writeback, 0 = line read
//   dc_addr_i     D-cache line address
//   dc_wdata_i    writeback line data
//   dc_ack_o      one-cycle pulse: D-cache transfer complete
//   fill_data_o   last line read from memory
//   mem_req_o     memory request, held until mem_ready_i
//   mem_we_o      write qualifier for mem_req_o
//   mem_addr_o    line-aligned memory address
//   mem_wdata_o   writeback data to memory
//   mem_ready_i   one-cycle pulse: memory finished the current request
//   mem_rdata_i   read data, valid with mem_ready_i
//   stall_core_o  pipeline stall to all latches
//
// Build option:
//   MEM_PORT_ARBITER_DPRIO_EN  when defined, the D-cache always wins a tie;
//                              otherwise ties are resolved round-robin.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] fill_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              stall_core_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Byte-offset bits within a line are cleared on the way to memory.
  localparam int              OFFS_W    = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFS_W;

  logic [1:0] state;
  logic       grant_d;

`ifndef MEM_PORT_ARBITER_DPRIO_EN
  // Remembers the winner of the most recent tie; 1 = D-cache.
  logic       last_grant_d;
`endif

  // Grant decision for IDLE. A lone requester always wins; on a tie the
  // D-cache wins under fixed priority, otherwise the side that lost the
  // previous tie wins.
  always_comb begin
    grant_d = dc_req_i;
`ifndef MEM_PORT_ARBITER_DPRIO_EN
    if (ic_req_i && dc_req_i) begin
      grant_d = ~last_grant_d;
    end
`endif
  end

  assign stall_core_o = (ic_req_i & ~ic_ack_o) | (dc_req_i & ~dc_ack_o);

  // Transfer sequencing. Memory-side outputs are captured at grant so they
  // stay stable for the whole transfer regardless of requester activity.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state        <= IDLE;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      fill_data_o  <= '0;
      ic_ack_o     <= 1'b0;
      dc_ack_o     <= 1'b0;
`ifndef MEM_PORT_ARBITER_DPRIO_EN
      last_grant_d <= 1'b1;
`endif
    end else begin
      ic_ack_o <= 1'b0;
      dc_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_req_i || dc_req_i) begin
            state       <= grant_d ? BUSY_D : BUSY_I;
            mem_req_o   <= 1'b1;
            mem_we_o    <= grant_d & dc_we_i;
            mem_addr_o  <= (grant_d ? dc_addr_i : ic_addr_i) & LINE_MASK;
            mem_wdata_o <= grant_d ? dc_wdata_i : '0;
`ifndef MEM_PORT_ARBITER_DPRIO_EN
            // Only ties move the round-robin pointer.
            if (ic_req_i && dc_req_i) begin
              last_grant_d <= grant_d;
            end
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready_i) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              fill_data_o <= mem_rdata_i;
            end
            ic_ack_o <= (state == BUSY_I);
            dc_ack_o <= (state == BUSY_D);
          end
        end
        RESP: begin
          // Requests are not sampled here; the acked requester is still
          // holding req during this cycle.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. The driver issues cache requests
// and pushes the transfers it expects to see on the memory port, in the
// order the arbitration rules dictate. A separate monitor acts as the
// memory: it pops expected transfers when mem_req_o is due, checks them,
// answers with mem_ready_i after a random delay and checks the resulting
// ack, fill data and stall.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int LINE_BYTES = LINE_W / 8;

  logic              clk_i = 1'b0;
  logic              rsn_i;
  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_ack_o;
  logic              dc_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic              dc_ack_o;
  logic [LINE_W-1:0] fill_data_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              stall_core_o;

  typedef struct {
    bit                is_d;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int                raise;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit mon_en   = 1'b0;
  bit busy     = 1'b0;
  bit ack_due  = 1'b0;
  int delay    = 0;
  int last_ack = -100;
  logic [LINE_W-1:0] model_fill = '0;

  bit                fix_en    = 1'b0;
  int                fix_delay = 0;
  logic [LINE_W-1:0] fix_rdata = '0;
  bit                stray_req = 1'b0;

  // Winner of the most recent tie in the reference model; 1 = D-cache.
  int rr_last_d = 1;

  bit mon_exp_ic, mon_exp_dc, mon_exp_stall;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .ic_req_i     (ic_req_i),
    .ic_addr_i    (ic_addr_i),
    .ic_ack_o     (ic_ack_o),
    .dc_req_i     (dc_req_i),
    .dc_we_i      (dc_we_i),
    .dc_addr_i    (dc_addr_i),
    .dc_wdata_i   (dc_wdata_i),
    .dc_ack_o     (dc_ack_o),
    .fill_data_o  (fill_data_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rdata_i  (mem_rdata_i),
    .stall_core_o (stall_core_o)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [LINE_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [ADDR_W-1:0] lineAddr(input logic [ADDR_W-1:0] a);
    return (a / LINE_BYTES) * LINE_BYTES;
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic pushTxn(input bit is_d, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] wd);
    txn_t t;
    t.is_d  = is_d;
    t.we    = is_d ? we : 1'b0;
    t.addr  = lineAddr(a);
    t.wdata = is_d ? wd : '0;
    t.raise = cyc;
    exp_q.push_back(t);
  endtask

  // Raises the requested cache requests (D after d_delay cycles, or together
  // with I when d_delay is 0), records the expected memory transfers in
  // grant order, and drops each request the cycle after its ack.
  task automatic applyStimulus(input bit do_i, input bit do_d, input int d_delay,
                               input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                               input bit dwe, input logic [LINE_W-1:0] dwd);
    bit i_pend, d_pend, d_raised, i_seen, d_seen, d_first;
    int k;
    i_pend   = do_i;
    d_pend   = do_d;
    d_raised = 1'b0;
    k        = 0;
    if (do_i) begin
      ic_addr_i = ia;
      ic_req_i  = 1'b1;
    end
    if (do_d && (!do_i || d_delay == 0)) begin
      dc_we_i    = dwe;
      dc_addr_i  = da;
      dc_wdata_i = dwd;
      dc_req_i   = 1'b1;
      d_raised   = 1'b1;
    end
    if (do_i && d_raised) begin
`ifdef MEM_PORT_ARBITER_DPRIO_EN
      d_first = 1'b1;
`else
      d_first   = (rr_last_d == 0);
      rr_last_d = d_first ? 1 : 0;
`endif
      if (d_first) begin
        pushTxn(1'b1, dwe, da, dwd);
        pushTxn(1'b0, 1'b0, ia, '0);
      end else begin
        pushTxn(1'b0, 1'b0, ia, '0);
        pushTxn(1'b1, dwe, da, dwd);
      end
    end else begin
      if (do_i) pushTxn(1'b0, 1'b0, ia, '0);
      if (d_raised) pushTxn(1'b1, dwe, da, dwd);
    end
    while ((i_pend || d_pend) && k < 80) begin
      @(negedge clk_i);
      i_seen = ic_ack_o;
      d_seen = dc_ack_o;
      @(posedge clk_i);
      #1;
      k++;
      if (i_seen && i_pend) begin
        ic_req_i = 1'b0;
        i_pend   = 1'b0;
      end
      if (d_seen && d_pend && d_raised) begin
        dc_req_i = 1'b0;
        d_pend   = 1'b0;
      end
      if (do_d && !d_raised && k >= d_delay) begin
        dc_we_i    = dwe;
        dc_addr_i  = da;
        dc_wdata_i = dwd;
        dc_req_i   = 1'b1;
        d_raised   = 1'b1;
        pushTxn(1'b1, dwe, da, dwd);
      end
    end
    if (i_pend || d_pend) begin
      checkOutput("handshake_timeout", 128'(1), 128'(0));
      ic_req_i = 1'b0;
      dc_req_i = 1'b0;
      exp_q.delete();
    end
  endtask

  // Memory model and monitor, evaluated on every falling edge.
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (mem_ready_i) begin
          mem_ready_i = 1'b0;
          mem_rdata_i = rand128();
        end
        mon_exp_ic    = ack_due && !cur.is_d;
        mon_exp_dc    = ack_due && cur.is_d;
        mon_exp_stall = (ic_req_i && !mon_exp_ic) || (dc_req_i && !mon_exp_dc);
        checkOutput("ic_ack", 128'(ic_ack_o), 128'(mon_exp_ic));
        checkOutput("dc_ack", 128'(dc_ack_o), 128'(mon_exp_dc));
        checkOutput("stall_core", 128'(stall_core_o), 128'(mon_exp_stall));
        if (ack_due) begin
          checkOutput("fill_data", fill_data_o, model_fill);
          checkOutput("mem_req_in_resp", 128'(mem_req_o), 128'(0));
          last_ack = cyc;
          ack_due  = 1'b0;
        end else begin
          if (!busy) begin
            if (exp_q.size() > 0 && cyc >= maxInt(exp_q[0].raise + 1, last_ack + 2)) begin
              cur   = exp_q.pop_front();
              busy  = 1'b1;
              delay = fix_en ? fix_delay : int'($urandom_range(0, 3));
            end else begin
              checkOutput("mem_req_idle", 128'(mem_req_o), 128'(0));
              if (exp_q.size() == 0 && (stray_req || $urandom_range(0, 7) == 0)) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = rand128();
                stray_req   = 1'b0;
              end
            end
          end
          if (busy) begin
            checkOutput("mem_req_busy", 128'(mem_req_o), 128'(1));
            checkOutput("mem_addr", 128'(mem_addr_o), 128'(cur.addr));
            checkOutput("mem_we", 128'(mem_we_o), 128'(cur.we));
            checkOutput("mem_wdata", mem_wdata_o, cur.wdata);
            if (delay == 0) begin
              mem_ready_i = 1'b1;
              mem_rdata_i = fix_en ? fix_rdata : rand128();
              if (!cur.we) model_fill = mem_rdata_i;
              busy    = 1'b0;
              ack_due = 1'b1;
            end else begin
              delay--;
            end
          end
        end
      end
    end
  end

  initial begin
    rsn_i      = 1'b0;
    ic_req_i   = 1'b0;
    ic_addr_i  = '0;
    dc_req_i   = 1'b0;
    dc_we_i    = 1'b0;
    dc_addr_i  = '0;
    dc_wdata_i = '0;

    #12;
    checkOutput("rst_mem_req", 128'(mem_req_o), 128'(0));
    checkOutput("rst_mem_we", 128'(mem_we_o), 128'(0));
    checkOutput("rst_mem_addr", 128'(mem_addr_o), 128'(0));
    checkOutput("rst_mem_wdata", mem_wdata_o, '0);
    checkOutput("rst_fill", fill_data_o, '0);
    checkOutput("rst_ic_ack", 128'(ic_ack_o), 128'(0));
    checkOutput("rst_dc_ack", 128'(dc_ack_o), 128'(0));
    checkOutput("rst_stall", 128'(stall_core_o), 128'(0));
    #10;
    rsn_i = 1'b1;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;

    // Directed: single I read, D writeback, ties, D arriving during I.
    fix_en    = 1'b1;
    fix_delay = 3;
    fix_rdata = {16{8'hA5}};
    applyStimulus(1'b1, 1'b0, 0, 32'h1000_0004, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 0, '0, 32'h2000_0010, 1'b1, 128'h1234);
    fix_delay = 1;
    fix_rdata = rand128();
    applyStimulus(1'b1, 1'b1, 0, 32'h0000_0100, 32'h0000_0204, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 0, 32'h0000_0308, 32'h0000_040C, 1'b1, rand128());
    fix_delay = 2;
    applyStimulus(1'b1, 1'b1, 2, 32'h0000_0500, 32'h0000_0600, 1'b0, '0);
    fix_en = 1'b0;

    // Stray mem_ready_i while idle must be ignored.
    stray_req = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      bit di, dd;
      di = 1'($urandom_range(0, 1));
      dd = 1'($urandom_range(0, 1));
      if (!di && !dd) dd = 1'b1;
      applyStimulus(di, dd, int'($urandom_range(0, 3)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), rand128());
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    // Reset in the middle of a D transfer.
    repeat (3) @(posedge clk_i);
    #1;
    mon_en     = 1'b0;
    dc_we_i    = 1'b0;
    dc_addr_i  = $urandom;
    dc_wdata_i = rand128();
    dc_req_i   = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("rst_pre_busy_d", 128'(mem_req_o), 128'(1));
    #2;
    rsn_i = 1'b0;
    #1;
    checkOutput("rst_async_mem_req", 128'(mem_req_o), 128'(0));
    checkOutput("rst_async_dc_ack", 128'(dc_ack_o), 128'(0));
    checkOutput("rst_async_fill", fill_data_o, '0);
    @(posedge clk_i);
    #1;
    dc_req_i = 1'b0;
    #3;
    rsn_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("post_rst_dc_ack", 128'(dc_ack_o), 128'(0));
      checkOutput("post_rst_mem_req", 128'(mem_req_o), 128'(0));
    end
    rr_last_d  = 1;
    last_ack   = -100;
    model_fill = '0;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;

    // After reset the round-robin pointer starts over: I wins the first tie.
    applyStimulus(1'b1, 1'b1, 0, 32'h3000_0014, 32'h4000_0028, 1'b0, '0);
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1'b1, 1'b1, int'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), rand128());
    end
    repeat (3) @(posedge clk_i);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
